// File: rtl/router_rd_sched.sv
// router_rd_sched
// Read-side scheduler for the 1x3 router. It watches the three router output
// FIFOs and drains one whole packet at a time. Channels are served
// round-robin, and the bytes are merged onto one valid/ready byte stream.
// Packet layout: header (length in [7:2], address in [1:0]), then length
// payload bytes, then one parity byte.
//
// Ports
//   clk, resetn                 clock (rising edge), async active-low reset
//   vld_out_0/1/2               router FIFO x non-empty
//   d_out_0/1/2 [7:0]           router FIFO x data, valid one cycle after a read
//   read_enb_0/1/2              read strobe to FIFO x (at most one high per cycle)
//   m_data [7:0], m_valid       merged output byte and its valid
//   m_ready                     downstream accept
//   m_chan [1:0]                source channel of m_data
//   m_sop, m_eop                m_data is the header / the parity byte
//   abort                       1-cycle pulse when a starved packet is abandoned
//   sched_busy                  a packet is locked (FSM not IDLE)
module router_rd_sched #(
  parameter int ABORT_CYC = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] d_out_0,
  input  logic [7:0] d_out_1,
  input  logic [7:0] d_out_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [1:0] m_chan,
  output logic       m_sop,
  output logic       m_eop,
  output logic       abort,
  output logic       sched_busy
);

  typedef enum logic [1:0] {IDLE, HDR, HWAIT, BODY} state_t;

  typedef struct packed {
    logic       eop;
    logic       sop;
    logic [1:0] chan;
    logic [7:0] data;
  } beat_t;

  localparam logic [7:0] STARVE_LAST = 8'(ABORT_CYC - 1);

  state_t     state_q, state_d;
  logic [1:0] chan_q, chan_d;
  logic [1:0] rr_q, rr_d;
  logic [6:0] rem_q, rem_d;
  logic [7:0] starve_q, starve_d;
  // Tags of the read issued last cycle; its data is captured this cycle.
  logic       infl_q, infl_d;
  logic [1:0] infl_chan_q, infl_chan_d;
  logic       infl_sop_q, infl_sop_d;
  logic       infl_eop_q, infl_eop_d;
  // Two-entry output skid buffer.
  beat_t      buf_q [2];
  beat_t      buf_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;

  logic [2:0] vld;
  logic       vld_c;
  logic       credit_ok;
  logic       rd_issue;
  logic       grant_ok;
  logic [1:0] grant_ch;
  logic [1:0] cand1, cand2;
  logic [7:0] d_cap;
  logic       push, pop;
  beat_t      head;

  function automatic logic [1:0] inc3(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  function automatic logic pick(input logic [2:0] v, input logic [1:0] c);
    case (c)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  assign vld   = {vld_out_2, vld_out_1, vld_out_0};
  assign vld_c = pick(vld, chan_q);
  assign cand1 = inc3(rr_q);
  assign cand2 = inc3(cand1);

  // The read data always belongs to the channel that the read targeted.
  always_comb begin
    case (infl_chan_q)
      2'd1:    d_cap = d_out_1;
      2'd2:    d_cap = d_out_2;
      default: d_cap = d_out_0;
    endcase
  end

  // A read is issued only when its byte is sure to find a free buffer slot.
  // That slot stays free whatever m_ready does.
  assign credit_ok = ({1'b0, cnt_q} + {2'b00, infl_q}) < 3'd2;

  // Round-robin search starting at the rr pointer.
  always_comb begin
    grant_ok = 1'b1;
    grant_ch = rr_q;
    if (pick(vld, rr_q))       grant_ch = rr_q;
    else if (pick(vld, cand1)) grant_ch = cand1;
    else if (pick(vld, cand2)) grant_ch = cand2;
    else                       grant_ok = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    rr_d       = rr_q;
    rem_d      = rem_q;
    starve_d   = starve_q;
    rd_issue   = 1'b0;
    abort      = 1'b0;
    infl_sop_d = 1'b0;
    infl_eop_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          chan_d  = grant_ch;
          state_d = HDR;
        end
      end
      HDR: begin
        if (vld_c && credit_ok) begin
          rd_issue   = 1'b1;
          infl_sop_d = 1'b1;
          state_d    = HWAIT;
        end
      end
      HWAIT: begin
        // The payload length plus the parity byte.
        rem_d   = {1'b0, d_cap[7:2]} + 7'd1;
        state_d = BODY;
      end
      BODY: begin
        if (vld_c && credit_ok && rem_q != 7'd0) begin
          rd_issue = 1'b1;
          rem_d    = rem_q - 7'd1;
          if (rem_q == 7'd1) begin
            infl_eop_d = 1'b1;
            state_d    = IDLE;
            rr_d       = inc3(chan_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Starvation watchdog on the locked channel. A firing watchdog needs
    // vld_c low, so no read can be issued in the same cycle.
    if (state_q == HDR || state_q == BODY) begin
      if (vld_c) begin
        starve_d = '0;
      end else if (starve_q == STARVE_LAST) begin
        abort    = 1'b1;
        state_d  = IDLE;
        rr_d     = inc3(chan_q);
        starve_d = '0;
      end else begin
        starve_d = starve_q + 8'd1;
      end
    end else if (state_q == IDLE || vld_c) begin
      starve_d = '0;
    end

    infl_d      = rd_issue;
    infl_chan_d = rd_issue ? chan_q : infl_chan_q;
  end

  assign push = infl_q;
  assign pop  = m_valid && m_ready;

  always_comb begin
    buf_d = buf_q;
    if (push) begin
      buf_d[wr_ptr_q].data = d_cap;
      buf_d[wr_ptr_q].chan = infl_chan_q;
      buf_d[wr_ptr_q].sop  = infl_sop_q;
      buf_d[wr_ptr_q].eop  = infl_eop_q;
    end
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      chan_q      <= '0;
      rr_q        <= '0;
      rem_q       <= '0;
      starve_q    <= '0;
      infl_q      <= 1'b0;
      infl_chan_q <= '0;
      infl_sop_q  <= 1'b0;
      infl_eop_q  <= 1'b0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      rr_q        <= rr_d;
      rem_q       <= rem_d;
      starve_q    <= starve_d;
      infl_q      <= infl_d;
      infl_chan_q <= infl_chan_d;
      infl_sop_q  <= infl_sop_d;
      infl_eop_q  <= infl_eop_d;
      buf_q[0]    <= buf_d[0];
      buf_q[1]    <= buf_d[1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign head       = buf_q[rd_ptr_q];
  assign m_valid    = (cnt_q != 2'd0);
  assign m_data     = m_valid ? head.data : 8'd0;
  assign m_chan     = m_valid ? head.chan : 2'd0;
  assign m_sop      = m_valid && head.sop;
  assign m_eop      = m_valid && head.eop;
  assign read_enb_0 = rd_issue && (chan_q == 2'd0);
  assign read_enb_1 = rd_issue && (chan_q == 2'd1);
  assign read_enb_2 = rd_issue && (chan_q == 2'd2);
  assign sched_busy = (state_q != IDLE);

endmodule
